// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Carries the fetch-stage {ce, pc} into decode and presents the instruction
// word to the decode stage. The instruction memory is synchronous-read, so
// its data arrives one cycle after the address. It therefore lines up with
// the PC latched here. It is normally passed straight through.
// When decode stalls while holding a real instruction, the memory read port
// moves on to other data. The word is then captured into inst_buf and
// replayed from there until the stall releases. A two-state FSM (RUN/HOLD)
// tracks this.
//
// Handshake: this block has no valid/ready pair. The stall vector is the
// only backpressure. When stall[1] is low, IF hands a new entry to ID. When
// stall[1] is high and stall[2] is low, ID empties into a bubble. When both
// are high, ID keeps its contents. flush overrides all of these.
module if_id_reg #(
    parameter int PC_WD    = 32,
    parameter int INST_WD  = 32,
    parameter int STALL_WD = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_WD-1:0] stall,
    input  logic                flush,
    input  logic [PC_WD:0]      if_to_id_bus,
    input  logic [INST_WD-1:0]  inst_sram_rdata,
    output logic                id_valid,
    output logic [PC_WD-1:0]    id_pc,
    output logic [INST_WD-1:0]  id_inst,
    output logic                dbg_state
);

    localparam logic NO_STOP = 1'b0;
    localparam logic STOP    = 1'b1;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [INST_WD-1:0] inst_buf;
    logic               if_stop;
    logic               id_stop;
    logic               bus_ce;
    logic [PC_WD-1:0]   bus_pc;
    logic               capture;

    // Only the IF and ID bits of the stall vector matter to this stage.
    assign if_stop = stall[1];
    assign id_stop = stall[2];

    // These stall bits belong to other stages and are ignored here.
    logic unused_stall;
    assign unused_stall = ^{stall[STALL_WD-1:3], stall[0]};

    assign bus_ce = if_to_id_bus[PC_WD];
    assign bus_pc = if_to_id_bus[PC_WD-1:0];

    // Pipeline payload: priority is flush, then advance, then bubble, then hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
        end else if (if_stop == NO_STOP) begin
            id_valid <= bus_ce;
            id_pc    <= bus_pc;
        end else if (id_stop == NO_STOP) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
        end
    end

    // State register for the RUN/HOLD replay machine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Enter HOLD only if a real instruction is stalled in
    // ID. Leave HOLD on stall release or on flush.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            RUN: begin
                if (id_stop == STOP && id_valid && !flush) begin
                    state_next = HOLD;
                    capture    = 1'b1;
                end
            end
            HOLD: begin
                if (id_stop == NO_STOP || flush) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Capture the read data only on the RUN->HOLD edge. It is frozen while in HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_buf <= '0;
        end else if (flush) begin
            inst_buf <= '0;
        end else if (capture) begin
            inst_buf <= inst_sram_rdata;
        end
    end

    // Instruction to decode: NOP when empty, else replay buffer or live memory data.
    always_comb begin
        id_inst = '0;
        if (id_valid) begin
            if (state == HOLD) begin
                id_inst = inst_buf;
            end else begin
                id_inst = inst_sram_rdata;
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_if_id_reg.sv
// Directed bench for if_id_reg: reset, advance, ID-stall replay, release,
// bubble, flush priority and asynchronous reset while holding.
module tb_if_id_reg;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [32:0] if_to_id_bus;
  logic [31:0] inst_sram_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        dbg_state;

  int n_checks;
  int n_fail;

  if_id_reg #(.PC_WD(32), .INST_WD(32), .STALL_WD(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_rdata (inst_sram_rdata),
    .id_valid        (id_valid),
    .id_pc           (id_pc),
    .id_inst         (id_inst),
    .dbg_state       (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic        ce;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic        exp_state;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic v, input logic [31:0] pc,
                               input logic [31:0] inst, input logic st);
    check({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, v});
    check({tag, ".id_pc"}, id_pc, pc);
    check({tag, ".id_inst"}, id_inst, inst);
    check({tag, ".state"}, {31'd0, dbg_state}, {31'd0, st});
  endtask

  // driver: drive inputs on the falling edge, sample 1 ns after the rising edge
  task automatic apply(input vec_t v);
    @(negedge clk);
    stall           = v.stall;
    flush           = v.flush;
    if_to_id_bus    = {v.ce, v.pc};
    inst_sram_rdata = v.rdata;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [5:0] s, input logic f, input logic ce,
                              input logic [31:0] pc, input logic [31:0] rd,
                              input logic ev, input logic [31:0] ep,
                              input logic [31:0] ei, input logic es);
    vec_t r;
    r.stall = s; r.flush = f; r.ce = ce; r.pc = pc; r.rdata = rd;
    r.exp_valid = ev; r.exp_pc = ep; r.exp_inst = ei; r.exp_state = es;
    return r;
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //              stall     fl ce pc            rdata         v  pc            inst          st
    vecs[0]  = mk(6'b000000, 0, 1, 32'hbfc00000, 32'h24080001, 1, 32'hbfc00000, 32'h24080001, 0);
    vecs[1]  = mk(6'b000000, 0, 1, 32'hbfc00004, 32'h8C020004, 1, 32'hbfc00004, 32'h8C020004, 0);
    vecs[2]  = mk(6'b000111, 0, 1, 32'hbfc00008, 32'h8C020004, 1, 32'hbfc00004, 32'h8C020004, 1);
    vecs[3]  = mk(6'b000111, 0, 1, 32'hbfc00008, 32'hDEADBEEF, 1, 32'hbfc00004, 32'h8C020004, 1);
    vecs[4]  = mk(6'b000111, 0, 1, 32'hbfc00008, 32'hDEADBEEF, 1, 32'hbfc00004, 32'h8C020004, 1);
    vecs[5]  = mk(6'b000000, 0, 1, 32'hbfc00008, 32'h3C010001, 1, 32'hbfc00008, 32'h3C010001, 0);
    vecs[6]  = mk(6'b000011, 0, 1, 32'hbfc0000c, 32'h11111111, 0, 32'h00000000, 32'h00000000, 0);
    vecs[7]  = mk(6'b000111, 0, 1, 32'hbfc0000c, 32'h22222222, 0, 32'h00000000, 32'h00000000, 0);
    vecs[8]  = mk(6'b000000, 0, 0, 32'hbfc0000c, 32'h33333333, 0, 32'hbfc0000c, 32'h00000000, 0);
    vecs[9]  = mk(6'b000000, 0, 1, 32'hbfc00010, 32'h1000FFFF, 1, 32'hbfc00010, 32'h1000FFFF, 0);
    vecs[10] = mk(6'b000111, 0, 1, 32'hbfc00014, 32'h1000FFFF, 1, 32'hbfc00010, 32'h1000FFFF, 1);
    vecs[11] = mk(6'b000111, 1, 1, 32'hbfc00014, 32'h44444444, 0, 32'h00000000, 32'h00000000, 0);
    vecs[12] = mk(6'b000000, 1, 1, 32'hbfc00014, 32'h45454545, 0, 32'h00000000, 32'h00000000, 0);
    vecs[13] = mk(6'b000000, 0, 1, 32'hbfc00018, 32'h55555555, 1, 32'hbfc00018, 32'h55555555, 0);

    // reset: outputs cleared before any clock edge
    rst             = 1'b1;
    stall           = 6'd0;
    flush           = 1'b0;
    if_to_id_bus    = '0;
    inst_sram_rdata = 32'hA5A5A5A5;
    #1;
    check_outputs("reset", 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // table-driven vectors
    for (int i = 0; i < 14; i++) begin
      apply(vecs[i]);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                    vecs[i].exp_inst, vecs[i].exp_state);
      if (i == 3) begin
        // live data keeps moving under HOLD; the decode word must not follow it
        inst_sram_rdata = 32'h0BADF00D;
        #1;
        check("hold_ignores_rdata", id_inst, 32'h8C020004);
      end
      if (i == 5) begin
        // back in RUN: id_inst tracks memory data combinationally
        inst_sram_rdata = 32'h12345678;
        #1;
        check("run_follows_rdata", id_inst, 32'h12345678);
      end
      if (i == 11) begin
        check("flush_clears_buf", dut.inst_buf, 32'h0);
      end
    end

    // asynchronous reset in the middle of a HOLD
    apply(mk(6'b000000, 0, 1, 32'hbfc00020, 32'h8C0A0010, 1, 32'h0, 32'h0, 0));
    apply(mk(6'b000111, 0, 1, 32'hbfc00024, 32'h8C0A0010, 1, 32'h0, 32'h0, 0));
    check_outputs("pre_async_rst", 1'b1, 32'hbfc00020, 32'h8C0A0010, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_outputs("async_rst", 1'b0, 32'h0, 32'h0, 1'b0);
    check("async_rst_buf", dut.inst_buf, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // first edge after reset release: stall still asserted with ID empty, no HOLD
    @(posedge clk);
    #1;
    check_outputs("post_rst_stall", 1'b0, 32'h0, 32'h0, 1'b0);

    // next edge with no stall advances immediately
    apply(mk(6'b000000, 0, 1, 32'hbfc00028, 32'h66666666, 1, 32'h0, 32'h0, 0));
    check_outputs("post_rst_adv", 1'b1, 32'hbfc00028, 32'h66666666, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
